fpdiv_iter: RTL and testbench
=============================

# fpdiv_iter

Iterative single-precision (IEEE-754 binary32) divider, the inverse operation to the team's pipelined FP32 multiplier. It uses the same operand/result/flags conventions, so software-visible results stay consistent across both units. It computes `a / b` with one quotient bit per cycle under a start/busy/done handshake, trading throughput for area. It sits beside the multiplier in the FP execution slice and shares its clock and reset.

## Interface
Parameters:
- none; format is fixed at binary32.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  32  dividend; captured on an accepted `start`.
- `b`  in  32  divisor; captured on an accepted `start`.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-cycle pulse; `result` and `flags` are valid with it.
- `result`  out  32  quotient.
- `flags`  out  5  bit 4 invalid, bit 3 divide-by-zero, bit 2 overflow, bit 1 underflow, bit 0 inexact.

## Operation
- FSM states: IDLE → UNPACK → DIVIDE → NORM → ROUND → IDLE.
- IDLE: `start`=1 latches `a` and `b`, then goes to UNPACK.
- UNPACK (1 cycle):
  - Split sign, exponent and mantissa. Sign = Sa^Sb.
  - Denormal inputs are flushed to signed zero.
  - Classify each operand as NaN, inf, zero or normal.
- DIVIDE (27 cycles):
  - Restoring division on 24-bit mantissas with the hidden 1. Initial remainder = Ma.
  - Each cycle: if rem ≥ Mb, set the q bit to 1 and subtract Mb from rem; then shift rem left by 1.
  - Produces q[26:0], MSB first.
- NORM (1 cycle):
  - If q[26]=1: mantissa = q[26:3], guard = q[2], sticky = |q[1:0] | (rem≠0).
  - Else: mantissa = q[25:2], guard = q[1], sticky = q[0] | (rem≠0).
  - Exponent is 10-bit signed: Ea − Eb + 127, minus 1 when q[26]=0.
- ROUND (1 cycle):
  - Apply the rounding mode (see Configuration).
  - A mantissa carry-out increments the exponent.
  - Exponent ≥ 255 → signed inf; sets overflow and inexact.
  - Exponent ≤ 0 → signed zero; sets underflow and inexact.
  - Otherwise inexact = guard | sticky.
- Special cases are decided in UNPACK but still take the full latency:
  - NaN operand, 0/0, or inf/inf → 0x7FC00000 with invalid set.
  - finite-nonzero/0 → signed inf with divide-by-zero set.
  - inf/finite → signed inf, no flags.
  - 0/finite or finite/inf → signed zero, no flags.
- `result` and `flags` hold their last value until the next `done`.

## Timing
- If `start` is sampled at edge k, `done`=1 in the cycle after edge k+30. Latency is fixed at 30 regardless of operands.
- `busy`=1 for cycles k+1 … k+30. `done` and `busy` are never high together in the same cycle.
- `start` while `busy`=1 or `done`=1 is ignored (no queueing).
- Back-to-back operation: `start` is accepted in the cycle after `done` at the earliest.
- Reset: state returns to IDLE; `busy`=0, `done`=0, `result`=0, `flags`=0.
- Reset mid-operation aborts the operation with no `done`; the first `start` after reset deasserts is accepted normally.
- Reset has priority over `start` in the same cycle.

## Configuration
- `FPDIV_ROUND_NEAREST_EN` defined: round-to-nearest-even. Round up when guard & (sticky | mantissa LSB).
- Not defined: truncate toward zero, with no rounding adder. Inexact is still reported as guard | sticky.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0) → `result`=0x40400000, `flags`=0, `done` exactly 30 cycles after `start`.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB with the macro, 0x3EAAAAAA without; `flags`=0x01 in both builds.
- 0x3F800000 / 0x00000000 → 0x7F800000, `flags`=0x08; 0x00000000 / 0x00000000 → 0x7FC00000, `flags`=0x10.
- 0x7F7FFFFF / 0x3F000000 → 0x7F800000, `flags`=0x05; 0x00800000 / 0x4B000000 → 0x00000000, `flags`=0x03.
- Pulse `start` at cycles 5 and 10 → only one `done` (at cycle 35), carrying the cycle-5 operands.
- Assert `rst` at cycle 15 of an operation → no `done`, all outputs 0; a new `start` after reset completes correctly.

Source files
------------

// File: rtl/fpdiv_if.sv
// Handshake and data bundle for the iterative FP32 divider.
// The requester drives start/a/b; the divider returns busy/done/result/flags.
interface fpdiv_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  flags;

  modport master (output start, a, b, input busy, done, result, flags);
  modport slave  (input start, a, b, output busy, done, result, flags);
endinterface

// File: rtl/fpdiv_iter.sv
// Iterative binary32 divider: restoring division, one quotient bit per cycle, fixed 30-cycle latency.
// Define FPDIV_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fpdiv_iter (
  input  logic  clk,
  input  logic  rst,
  fpdiv_if.slave bus
);

  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, ROUND} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        a_reg, b_reg;
  logic [4:0]         count_reg;
  logic [25:0]        rem_reg;
  logic [23:0]        divisor_reg;
  logic [26:0]        q_reg;
  logic               sign_reg;
  logic signed [9:0]  exp_reg;
  logic [23:0]        man_reg;
  logic               guard_reg, sticky_reg;
  logic               special_reg;
  logic [31:0]        special_result_reg;
  logic [4:0]         special_flags_reg;
  logic               done_reg;
  logic [31:0]        result_reg;
  logic [4:0]         flags_reg;

  // A start coinciding with the done pulse is dropped, so back-to-back issue waits one cycle.
  logic accept;
  assign accept = (state_reg == IDLE) && bus.start && !done_reg;

  // Operand classification; denormals are flushed by treating exponent 0 as zero.
  logic [7:0]  op_exp  [2];
  logic [22:0] op_frac [2];
  logic [23:0] op_man  [2];
  logic        op_nan  [2];
  logic        op_inf  [2];
  logic        op_zero [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign op_exp[gi]  = (gi == 0) ? a_reg[30:23] : b_reg[30:23];
    assign op_frac[gi] = (gi == 0) ? a_reg[22:0]  : b_reg[22:0];
    assign op_nan[gi]  = (op_exp[gi] == 8'hFF) && (op_frac[gi] != 23'd0);
    assign op_inf[gi]  = (op_exp[gi] == 8'hFF) && (op_frac[gi] == 23'd0);
    assign op_zero[gi] = (op_exp[gi] == 8'h00);
    assign op_man[gi]  = op_zero[gi] ? 24'd0 : {1'b1, op_frac[gi]};
  end

  logic        sign_now;
  logic        spec_hit;
  logic [31:0] spec_result;
  logic [4:0]  spec_flags;

  assign sign_now = a_reg[31] ^ b_reg[31];

  always_comb begin
    spec_hit    = 1'b1;
    spec_result = 32'h7FC0_0000;
    spec_flags  = 5'b10000;
    if (op_nan[0] || op_nan[1] || (op_zero[0] && op_zero[1]) || (op_inf[0] && op_inf[1])) begin
      spec_hit = 1'b1;
    end else if (op_inf[0]) begin
      spec_result = {sign_now, 8'hFF, 23'd0};
      spec_flags  = 5'b00000;
    end else if (op_zero[1]) begin
      spec_result = {sign_now, 8'hFF, 23'd0};
      spec_flags  = 5'b01000;
    end else if (op_zero[0] || op_inf[1]) begin
      spec_result = {sign_now, 31'd0};
      spec_flags  = 5'b00000;
    end else begin
      spec_hit    = 1'b0;
      spec_result = 32'd0;
      spec_flags  = 5'b00000;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = UNPACK;
      UNPACK:  state_next = DIVIDE;
      DIVIDE:  if (count_reg == 5'd26) state_next = NORM;
      NORM:    state_next = ROUND;
      ROUND:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  logic rem_ge;
  logic rem_nz;
  assign rem_ge = (rem_reg >= {2'b00, divisor_reg});
  assign rem_nz = (rem_reg != 26'd0);

  always_ff @(posedge clk) begin
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          a_reg <= bus.a;
          b_reg <= bus.b;
        end
      end
      UNPACK: begin
        sign_reg           <= sign_now;
        exp_reg            <= $signed({2'b00, op_exp[0]}) - $signed({2'b00, op_exp[1]}) + 10'sd127;
        rem_reg            <= {2'b00, op_man[0]};
        divisor_reg        <= op_man[1];
        q_reg              <= 27'd0;
        count_reg          <= 5'd0;
        special_reg        <= spec_hit;
        special_result_reg <= spec_result;
        special_flags_reg  <= spec_flags;
      end
      DIVIDE: begin
        if (rem_ge) begin
          rem_reg <= (rem_reg - {2'b00, divisor_reg}) << 1;
          q_reg   <= {q_reg[25:0], 1'b1};
        end else begin
          rem_reg <= rem_reg << 1;
          q_reg   <= {q_reg[25:0], 1'b0};
        end
        count_reg <= count_reg + 5'd1;
      end
      NORM: begin
        if (q_reg[26]) begin
          man_reg    <= q_reg[26:3];
          guard_reg  <= q_reg[2];
          sticky_reg <= (|q_reg[1:0]) | rem_nz;
        end else begin
          man_reg    <= q_reg[25:2];
          guard_reg  <= q_reg[1];
          sticky_reg <= q_reg[0] | rem_nz;
          exp_reg    <= exp_reg - 10'sd1;
        end
      end
      default: begin
      end
    endcase
  end

  logic [24:0]       man_sum;
  logic signed [9:0] exp_rnd;
  logic [22:0]       frac_rnd;
  logic [31:0]       round_result;
  logic [4:0]        round_flags;

  always_comb begin
`ifdef FPDIV_ROUND_NEAREST_EN
    man_sum = {1'b0, man_reg} + {24'd0, guard_reg & (sticky_reg | man_reg[0])};
`else
    man_sum = {1'b0, man_reg};
`endif
    // A carry out leaves 1.000...; the fraction field is zero either way.
    exp_rnd  = exp_reg + $signed({9'd0, man_sum[24]});
    frac_rnd = man_sum[24] ? man_sum[23:1] : man_sum[22:0];
    if (special_reg) begin
      round_result = special_result_reg;
      round_flags  = special_flags_reg;
    end else if (exp_rnd >= 10'sd255) begin
      round_result = {sign_reg, 8'hFF, 23'd0};
      round_flags  = 5'b00101;
    end else if (exp_rnd <= 10'sd0) begin
      round_result = {sign_reg, 31'd0};
      round_flags  = 5'b00011;
    end else begin
      round_result = {sign_reg, exp_rnd[7:0], frac_rnd};
      round_flags  = {4'b0000, guard_reg | sticky_reg};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_reg   <= 1'b0;
      result_reg <= 32'd0;
      flags_reg  <= 5'd0;
    end else begin
      done_reg <= (state_reg == ROUND);
      if (state_reg == ROUND) begin
        result_reg <= round_result;
        flags_reg  <= round_flags;
      end
    end
  end

  assign bus.busy   = (state_reg != IDLE);
  assign bus.done   = done_reg;
  assign bus.result = result_reg;
  assign bus.flags  = flags_reg;

endmodule

// File: tb/tb_fpdiv_iter.sv
// Self-checking bench for fpdiv_iter: directed corner cases, random operands against an
// integer-arithmetic reference model, and handshake/reset timing scenarios.
module tb_fpdiv_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fpdiv_if bus ();

  fpdiv_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: exact integer quotient of the significands, then rounding.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [4:0] f);
    int ex, ey, e;
    logic s, xnan, ynan, xinf, yinf, xz, yz, guard, sticky;
    longint unsigned ma, mb, num, q, rm, man;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xnan = (ex == 255) && (x[22:0] != 0);
    ynan = (ey == 255) && (y[22:0] != 0);
    xinf = (ex == 255) && (x[22:0] == 0);
    yinf = (ey == 255) && (y[22:0] == 0);
    xz = (ex == 0);
    yz = (ey == 0);
    if (xnan || ynan || (xz && yz) || (xinf && yinf)) begin
      r = 32'h7FC00000; f = 5'h10; return;
    end
    if (xinf) begin r = {s, 8'hFF, 23'h0}; f = 5'h00; return; end
    if (yz)   begin r = {s, 8'hFF, 23'h0}; f = 5'h08; return; end
    if (xz || yinf) begin r = {s, 31'h0}; f = 5'h00; return; end
    ma = longint'({1'b1, x[22:0]});
    mb = longint'({1'b1, y[22:0]});
    e  = ex - ey + 127;
    if (ma < mb) begin
      ma = ma * 2;
      e  = e - 1;
    end
    num = ma << 25;
    q   = num / mb;
    rm  = num % mb;
    man = q >> 2;
    guard  = q[1];
    sticky = q[0] | (rm != 0);
`ifdef FPDIV_ROUND_NEAREST_EN
    if (guard && (sticky || man[0])) man = man + 1;
    if (man == (64'd1 << 24)) begin
      man = man >> 1;
      e   = e + 1;
    end
`endif
    if (e >= 255) begin
      r = {s, 8'hFF, 23'h0}; f = 5'h05;
    end else if (e <= 0) begin
      r = {s, 31'h0}; f = 5'h03;
    end else begin
      r = {s, 8'(e), man[22:0]}; f = {4'b0, guard | sticky};
    end
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 19);
    case (k)
      0: w[30:0] = 31'h0;
      1: w[30:0] = {8'hFF, 23'h0};
      2: begin w[30:23] = 8'hFF; w[0] = 1'b1; end
      3: w[30:23] = 8'h00;
      4: w[30:23] = 8'hFE;
      5: w[30:23] = 8'h01;
      default: w[30:23] = 8'($urandom_range(1, 254));
    endcase
    return w;
  endfunction

  // Drives one accepted start; returns #1 after the accepting edge.
  task automatic launch(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    while (bus.done === 1'b1) @(negedge clk);
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
  endtask

  // Counts edges from acceptance to done and tallies busy/done protocol violations.
  task automatic wait_done(output int lat, output logic [31:0] res, output logic [4:0] fl,
                           output int bad);
    lat = 0;
    bad = (bus.busy !== 1'b1) ? 1 : 0;
    while (bus.done !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done !== 1'b1 && bus.busy !== 1'b1) bad++;
      if (bus.done === 1'b1 && bus.busy !== 1'b0) bad++;
    end
    res = bus.result;
    fl  = bus.flags;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = 32'h40C00000;
    bus.b = 32'h40000000;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.busy, bus.done, bus.result, bus.flags} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%08h flags=%02h, required all zero",
               bus.busy, bus.done, bus.result, bus.flags);
    end
    $display("reset: busy=%b done=%b result=%08h flags=%02h", bus.busy, bus.done, bus.result, bus.flags);
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_directed();
    logic [31:0] x, y, er, res;
    logic [4:0] ef, fl;
    int lat, bad;
    for (int i = 0; i < 13; i++) begin
      case (i)
        0:  begin x = 32'h40C00000; y = 32'h40000000; er = 32'h40400000; ef = 5'h00; end
`ifdef FPDIV_ROUND_NEAREST_EN
        1:  begin x = 32'h3F800000; y = 32'h40400000; er = 32'h3EAAAAAB; ef = 5'h01; end
`else
        1:  begin x = 32'h3F800000; y = 32'h40400000; er = 32'h3EAAAAAA; ef = 5'h01; end
`endif
        2:  begin x = 32'h3F800000; y = 32'h00000000; er = 32'h7F800000; ef = 5'h08; end
        3:  begin x = 32'h00000000; y = 32'h00000000; er = 32'h7FC00000; ef = 5'h10; end
        4:  begin x = 32'h7F7FFFFF; y = 32'h3F000000; er = 32'h7F800000; ef = 5'h05; end
        5:  begin x = 32'h00800000; y = 32'h4B000000; er = 32'h00000000; ef = 5'h03; end
        6:  begin x = 32'hFF800000; y = 32'h40000000; er = 32'hFF800000; ef = 5'h00; end
        7:  begin x = 32'h40000000; y = 32'h7F800000; er = 32'h00000000; ef = 5'h00; end
        8:  begin x = 32'h7F800000; y = 32'hFF800000; er = 32'h7FC00000; ef = 5'h10; end
        9:  begin x = 32'h7F800001; y = 32'h3F800000; er = 32'h7FC00000; ef = 5'h10; end
        10: begin x = 32'hBF800000; y = 32'h00000000; er = 32'hFF800000; ef = 5'h08; end
        11: begin x = 32'h00400000; y = 32'hBF800000; er = 32'h80000000; ef = 5'h00; end
        default: begin x = 32'hC1200000; y = 32'h40A00000; er = 32'hC0000000; ef = 5'h00; end
      endcase
      launch(x, y);
      wait_done(lat, res, fl, bad);
      $display("dir %0d: %08h / %08h -> %08h flags %02h lat %0d", i, x, y, res, fl, lat);
      n_vec++;
      if (res !== er || fl !== ef) begin
        n_err++;
        $display("FAIL dir_%0d: got %08h/%02h, required %08h/%02h", i, res, fl, er, ef);
      end
      n_vec++;
      if (lat !== 30 || bad !== 0) begin
        n_err++;
        $display("FAIL dir_timing_%0d: got latency %0d (%0d busy errors), required 30 (0)", i, lat, bad);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, er, res;
    logic [4:0] ef, fl;
    int lat, bad;
    for (int i = 0; i < 70; i++) begin
      x = rand_operand();
      y = rand_operand();
      ref_div(x, y, er, ef);
      launch(x, y);
      wait_done(lat, res, fl, bad);
      $display("rnd %0d: %08h / %08h -> %08h flags %02h lat %0d", i, x, y, res, fl, lat);
      n_vec++;
      if (res !== er || fl !== ef || lat !== 30 || bad !== 0) begin
        n_err++;
        $display("FAIL rnd_%0d: a=%08h b=%08h got %08h/%02h lat %0d bad %0d, required %08h/%02h lat 30",
                 i, x, y, res, fl, lat, bad, er, ef);
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [31:0] er, res;
    logic [4:0] ef, fl;
    int lat, bad, extra;
    ref_div(32'h3F800000, 32'h40400000, er, ef);
    launch(32'h3F800000, 32'h40400000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'h40C00000;
    bus.b = 32'h40000000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat, res, fl, bad);
    lat = lat + 5;
    $display("ignored-start: -> %08h flags %02h lat %0d", res, fl, lat);
    n_vec++;
    if (res !== er || fl !== ef || lat !== 30) begin
      n_err++;
      $display("FAIL ignored_start: got %08h/%02h lat %0d, required %08h/%02h lat 30", res, fl, lat, er, ef);
    end
    extra = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
    end
    n_vec++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL ignored_second_op: got %0d active cycles, required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] er, res;
    logic [4:0] ef, fl;
    int lat, bad;
    launch(32'h40C00000, 32'h40000000);
    wait_done(lat, res, fl, bad);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 32'h3F800000;
    bus.b = 32'h40400000;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_during_done: got busy=%b, required 0", bus.busy);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b, required 1", bus.busy);
    end
    ref_div(32'h3F800000, 32'h40400000, er, ef);
    wait_done(lat, res, fl, bad);
    $display("back-to-back: -> %08h flags %02h lat %0d", res, fl, lat);
    n_vec++;
    if (res !== er || fl !== ef || lat !== 30 || bad !== 0) begin
      n_err++;
      $display("FAIL b2b_result: got %08h/%02h lat %0d, required %08h/%02h lat 30", res, fl, lat, er, ef);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] er, res;
    logic [4:0] ef, fl;
    int lat, bad, seen;
    launch(32'h7F7FFFFF, 32'h3F000000);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({bus.busy, bus.done, bus.result, bus.flags} !== 39'd0) begin
      n_err++;
      $display("FAIL abort_outputs: got busy=%b done=%b result=%08h flags=%02h, required all zero",
               bus.busy, bus.done, bus.result, bus.flags);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL abort_no_done: got %0d done pulses, required 0", seen);
    end
    ref_div(32'hC1200000, 32'h3F400000, er, ef);
    launch(32'hC1200000, 32'h3F400000);
    wait_done(lat, res, fl, bad);
    $display("after-abort: -> %08h flags %02h lat %0d", res, fl, lat);
    n_vec++;
    if (res !== er || fl !== ef || lat !== 30 || bad !== 0) begin
      n_err++;
      $display("FAIL abort_restart: got %08h/%02h lat %0d, required %08h/%02h lat 30", res, fl, lat, er, ef);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
